// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : registered, handshaked ALU with 2*WIDTH accumulator, shift-add MUL
// Revision : 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         sel,
  input  logic               chain,
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] acc,
  output logic               zero,
  output logic               out_valid
);

  localparam int c_AW = 2 * WIDTH;
  localparam int c_CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_p;
  logic [WIDTH-1:0]  r_q;
  logic [c_AW-1:0]   r_partial;

  logic              w_accept;
  logic              w_last;
  logic [WIDTH-1:0]  w_p;
  logic [c_AW-1:0]   w_pe;
  logic [c_AW-1:0]   w_qe;
  logic [WIDTH-1:0]  w_shamt;
  logic [c_AW-1:0]   w_res;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == c_CW'(WIDTH - 1));
  assign w_p      = chain ? acc[WIDTH-1:0] : p;
  assign w_pe     = {{WIDTH{1'b0}}, w_p};
  assign w_qe     = {{WIDTH{1'b0}}, q};
  assign w_shamt  = WIDTH'(q % WIDTH'(c_AW));

  always_comb begin
    w_res = '0;
    case (sel)
      3'd0:    w_res = w_pe + w_qe;
      3'd1:    w_res = w_pe - w_qe;
      3'd3:    w_res = w_pe & w_qe;
      3'd4:    w_res = w_pe | w_qe;
      3'd5:    w_res = w_pe ^ w_qe;
      3'd6:    w_res = {{WIDTH{1'b0}}, ~w_p};
      3'd7:    w_res = w_pe << w_shamt;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && sel == 3'd2) w_state_nxt = S_MUL;
      S_MUL:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      r_cnt     <= '0;
      r_p       <= '0;
      r_q       <= '0;
      r_partial <= '0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (sel == 3'd2) begin
              r_p       <= w_p;
              r_q       <= q;
              r_cnt     <= '0;
              r_partial <= '0;
            end else begin
              acc       <= w_res;
              zero      <= (w_res == '0);
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          // One multiplier bit per cycle, LSB first.
          if (r_q[r_cnt])
            r_partial <= r_partial + ({{WIDTH{1'b0}}, r_p} << r_cnt);
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          acc       <= r_partial;
          zero      <= (r_partial == '0);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
